nibble_serial_adder: RTL

//   Adds two WIDTH-bit operands plus carry-in, one 4-bit nibble per clock, through
//   one instance of adder_4bit (LSB nibble first), with a registered carry between nibbles.

---
 rtl/nibble_serial_adder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one adder_4bit reused LSB nibble first.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [WIDTH+3:0] sum_cat;
  logic [WIDTH-1:0] sum_nxt;
`ifdef OVERFLOW_FLAG_EN
  logic             a_msb;
  logic             b_msb;
`endif

  adder_4bit u_add (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // New nibble enters at the top; after NIBBLES shifts it is fully aligned.
  assign sum_cat = {nib_sum, sum};
  assign sum_nxt = sum_cat[WIDTH+3:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          sum   <= sum_nxt;
          carry <= nib_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= nib_cout;
`ifdef OVERFLOW_FLAG_EN
            ovf <= (a_msb == b_msb) && (nib_sum[3] != a_msb);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
